// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES
// ripple slices with a valid/ready handshake; flags and optional saturation in the last stage.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             M,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SW = (STAGES >= 1) ? WIDTH / STAGES : 1;

  generate
    if (STAGES < 1 || WIDTH < 2 || (WIDTH % ((STAGES >= 1) ? STAGES : 1)) != 0) begin : g_bad_params
      $error("pipelined_addsub: need WIDTH >= 2, STAGES >= 1 and WIDTH divisible by STAGES");
    end
  endgenerate

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_vin;

  logic [WIDTH-1:0]  r_sum;
  logic              r_c_out;
  logic              r_ovf;
  logic              r_zero;
  logic              r_neg;

  // Advance ripples back from the consumer so a bubble anywhere lets upstream stages move.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = !r_v[k+1] || w_adv[k+1];
    end
    w_load = ~r_v | w_adv;
    w_vin = '0;
    w_vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_vin[k] = r_v[k-1];
    end
  end

  assign in_ready = !rst && w_load[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) r_v[k] <= w_vin[k];
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      // w_ra_in: finished low slices below slice k, untouched a above; w_xh_in: unprocessed x slices.
      logic [WIDTH-1:0]      w_ra_in;
      logic [WIDTH-k*SW-1:0] w_xh_in;
      logic                  w_cin;
      logic                  w_sat_in;
      logic [SW:0]           w_s;

      if (k == 0) begin : g_first
        assign w_ra_in  = a;
        assign w_xh_in  = b ^ {WIDTH{M}};
        assign w_cin    = M;
        assign w_sat_in = sat;
      end else begin : g_link
        assign w_ra_in  = g_stage[k-1].g_mid.r_ra;
        assign w_xh_in  = g_stage[k-1].g_mid.r_xh;
        assign w_cin    = g_stage[k-1].g_mid.r_c;
        assign w_sat_in = g_stage[k-1].g_mid.r_sat;
      end

      assign w_s = {1'b0, w_ra_in[k*SW +: SW]} + {1'b0, w_xh_in[SW-1:0]} + {{SW{1'b0}}, w_cin};

      if (k < STAGES - 1) begin : g_mid
        logic [WIDTH-1:0]          r_ra;
        logic [WIDTH-(k+1)*SW-1:0] r_xh;
        logic                      r_c;
        logic                      r_sat;
        logic [WIDTH-1:0]          w_ra_nx;

        always_comb begin
          w_ra_nx = w_ra_in;
          w_ra_nx[k*SW +: SW] = w_s[SW-1:0];
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            r_ra  <= '0;
            r_xh  <= '0;
            r_c   <= 1'b0;
            r_sat <= 1'b0;
          end else if (w_load[k] && w_vin[k]) begin
            r_ra  <= w_ra_nx;
            r_xh  <= w_xh_in[WIDTH-k*SW-1:SW];
            r_c   <= w_s[SW];
            r_sat <= w_sat_in;
          end
        end
      end else begin : g_last
        logic [WIDTH-1:0] w_raw;
        logic [WIDTH-1:0] w_res;
        logic             w_ovf;

        // The top slice of a and x is still unprocessed here, so their MSBs are available for ovf.
        always_comb begin
          w_raw = w_ra_in;
          w_raw[WIDTH-1 -: SW] = w_s[SW-1:0];
          w_ovf = (w_ra_in[WIDTH-1] == w_xh_in[SW-1]) && (w_raw[WIDTH-1] != w_ra_in[WIDTH-1]);
          w_res = w_raw;
          if (w_sat_in && w_ovf) begin
            w_res = w_ra_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
          end else if (w_load[k] && w_vin[k]) begin
            r_sum   <= w_res;
            r_c_out <= w_s[SW];
            r_ovf   <= w_ovf;
            r_zero  <= (w_res == '0);
            r_neg   <= w_res[WIDTH-1];
          end
        end
      end
    end
  endgenerate

  assign out_valid = r_v[STAGES-1];
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: scoreboard on the 4-stage instance plus
// 1/2/16-stage instances sharing the stimulus for the latency sweep.
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst, in_valid, M, sat, out_ready;
  logic [15:0] a, b;

  logic        in_ready, out_valid, c_out, ovf, zero, neg;
  logic [15:0] sum;
  logic        in_ready_s1, out_valid_s1, c_out_s1, ovf_s1, zero_s1, neg_s1;
  logic [15:0] sum_s1;
  logic        in_ready_s2, out_valid_s2, c_out_s2, ovf_s2, zero_s2, neg_s2;
  logic [15:0] sum_s2;
  logic        in_ready_s16, out_valid_s16, c_out_s16, ovf_s16, zero_s16, neg_s16;
  logic [15:0] sum_s16;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
  } res_t;

  res_t sbq[$];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .M(M), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero), .neg(neg));

  pipelined_addsub #(.WIDTH(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s1), .a(a), .b(b), .M(M), .sat(sat),
    .out_valid(out_valid_s1), .out_ready(out_ready), .sum(sum_s1), .c_out(c_out_s1), .ovf(ovf_s1),
    .zero(zero_s1), .neg(neg_s1));

  pipelined_addsub #(.WIDTH(16), .STAGES(2)) dut_s2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s2), .a(a), .b(b), .M(M), .sat(sat),
    .out_valid(out_valid_s2), .out_ready(out_ready), .sum(sum_s2), .c_out(c_out_s2), .ovf(ovf_s2),
    .zero(zero_s2), .neg(neg_s2));

  pipelined_addsub #(.WIDTH(16), .STAGES(16)) dut_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s16), .a(a), .b(b), .M(M), .sat(sat),
    .out_valid(out_valid_s16), .out_ready(out_ready), .sum(sum_s16), .c_out(c_out_s16), .ovf(ovf_s16),
    .zero(zero_s16), .neg(neg_s16));

  // Reference: overflow from exact integer arithmetic, carry from a 17-bit add.
  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mm, input logic ms);
    res_t        r;
    int          ia, ib, tr;
    logic [16:0] full;
    ia = $signed(ma);
    ib = $signed(mb);
    tr = mm ? ia - ib : ia + ib;
    full = mm ? ({1'b0, ma} + {1'b0, ~mb} + 17'd1) : ({1'b0, ma} + {1'b0, mb});
    r.c = full[16];
    r.o = (tr > 32767) || (tr < -32768);
    if (ms && r.o) r.s = (tr > 0) ? 16'h7FFF : 16'h8000;
    else           r.s = tr[15:0];
    r.z = (r.s == 16'h0000);
    r.n = r.s[15];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("stale_output", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sbq.pop_front();
          n_pops++;
          check("sb_sum",  {16'd0, sum},   {16'd0, e.s});
          check("sb_cout", {31'd0, c_out}, {31'd0, e.c});
          check("sb_ovf",  {31'd0, ovf},   {31'd0, e.o});
          check("sb_zero", {31'd0, zero},  {31'd0, e.z});
          check("sb_neg",  {31'd0, neg},   {31'd0, e.n});
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(a, b, M, sat));
    end
  end

  task automatic op_check(input logic [15:0] ta, input logic [15:0] tb, input logic tm, input logic ts,
                          input logic [15:0] es, input logic ec, input logic eo, input logic ez,
                          input logic en, input string tag);
    int w;
    int lat;
    a = ta; b = tb; M = tm; sat = ts; in_valid = 1'b1;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
    step;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step;
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_sum"},  {16'd0, sum},   {16'd0, es});
    check({tag, "_cout"}, {31'd0, c_out}, {31'd0, ec});
    check({tag, "_ovf"},  {31'd0, ovf},   {31'd0, eo});
    check({tag, "_zero"}, {31'd0, zero},  {31'd0, ez});
    check({tag, "_neg"},  {31'd0, neg},   {31'd0, en});
  endtask

  task automatic drain;
    int w;
    w = 0;
    while ((sbq.size() != 0 || out_valid) && w < 60) begin
      step;
      w++;
    end
    check("drain_empty", sbq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held_sum;
    logic [3:0]  held_flags;
    logic        acc;
    logic        stale;
    int          idx, cyc, pops0;
    int          lat1, lat2, lat4, lat16;
    logic [15:0] ra[8];
    logic [15:0] rb[8];
    logic        rm[8];
    logic        rs[8];

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; M = 1'b0; sat = 1'b0; out_ready = 1'b1;
    repeat (3) step;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    step;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_outputs",   {11'd0, sum, c_out, ovf, zero, neg, 1'b0}, 32'd0);
    step;

    op_check(16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0, 1'b0, 1'b0, "add");
    op_check(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, "sub_borrow");
    op_check(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, "sub_noborrow");
    op_check(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, "ovf_wrap");
    op_check(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, "ovf_sat_max");
    op_check(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, "ovf_sat_min");
    drain;

    // Cross-slice carry through every pipeline depth; let the deep instance empty first.
    repeat (20) step;
    a = 16'hFFFF; b = 16'h0001; M = 1'b0; sat = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("xc_accept", {28'd0, in_ready, in_ready_s1, in_ready_s2, in_ready_s16}, 32'hF);
    step;
    in_valid = 1'b0;
    lat1 = 0; lat2 = 0; lat4 = 0; lat16 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (lat1 == 0 && out_valid_s1) begin
        lat1 = c;
        check("xc_s1_res", {13'd0, sum_s1, c_out_s1, ovf_s1, zero_s1}, {13'd0, 16'h0000, 3'b101});
      end
      if (lat2 == 0 && out_valid_s2) begin
        lat2 = c;
        check("xc_s2_res", {13'd0, sum_s2, c_out_s2, ovf_s2, zero_s2}, {13'd0, 16'h0000, 3'b101});
      end
      if (lat4 == 0 && out_valid) begin
        lat4 = c;
        check("xc_s4_res", {13'd0, sum, c_out, ovf, zero}, {13'd0, 16'h0000, 3'b101});
      end
      if (lat16 == 0 && out_valid_s16) begin
        lat16 = c;
        check("xc_s16_res", {13'd0, sum_s16, c_out_s16, ovf_s16, zero_s16}, {13'd0, 16'h0000, 3'b101});
      end
      step;
    end
    check("xc_s1_latency",  lat1,  32'd1);
    check("xc_s2_latency",  lat2,  32'd2);
    check("xc_s4_latency",  lat4,  32'd4);
    check("xc_s16_latency", lat16, 32'd16);
    drain;

    // Backpressure: consumer stalls for cycles 3..7 of a back-to-back burst of 8.
    for (int i = 0; i < 8; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rm[i] = 1'($urandom);
      rs[i] = 1'($urandom);
    end
    pops0 = n_pops;
    idx = 0; cyc = 0;
    held_sum = '0; held_flags = '0;
    while (idx < 8 && cyc < 40) begin
      a = ra[idx]; b = rb[idx]; M = rm[idx]; sat = rs[idx]; in_valid = 1'b1;
      out_ready = !(cyc >= 3 && cyc < 8);
      @(negedge clk);
      acc = in_ready;
      if (cyc == 3) check("bp_accept_4th", {31'd0, in_ready}, 32'd1);
      if (cyc == 4) begin
        held_sum = sum;
        held_flags = {c_out, ovf, zero, neg};
      end
      if (cyc >= 4 && cyc < 8) begin
        check("bp_in_ready_low", {31'd0, in_ready},  32'd0);
        check("bp_out_valid",    {31'd0, out_valid}, 32'd1);
        check("bp_hold", {12'd0, sum, c_out, ovf, zero, neg}, {12'd0, held_sum, held_flags});
      end
      if (cyc == 8) check("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
      step;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_all_accepted", idx, 32'd8);
    drain;
    check("bp_results_count", n_pops - pops0, 32'd8);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); M = 1'b0; sat = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check("rm_accept", {31'd0, in_ready}, 32'd1);
      step;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rm_rst_in_ready", {31'd0, in_ready}, 32'd0);
    step;
    rst = 1'b0;
    @(negedge clk);
    check("rm_out_valid", {31'd0, out_valid}, 32'd0);
    check("rm_outputs",   {11'd0, sum, c_out, ovf, zero, neg, 1'b0}, 32'd0);
    check("rm_in_ready",  {31'd0, in_ready}, 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step;
      if (out_valid) stale = 1'b1;
    end
    check("rm_no_stale", {31'd0, stale}, 32'd0);
    op_check(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, "rm_new_op");
    drain;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
